// File: rtl/inst_cache_if.sv
// Fetch-side and fill-side signals of the direct-mapped instruction cache.
// The slave modport is the cache view; the master modport is the CPU/memory view.
interface inst_cache_if;
    logic [15:0] addr;
    logic        flush;
    logic [15:0] inst;
    logic        hit;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready;
    logic [15:0] mem_data;

    modport slave (
        input  addr, flush, mem_ready, mem_data,
        output inst, hit, mem_req, mem_addr
    );

    modport master (
        output addr, flush, mem_ready, mem_data,
        input  inst, hit, mem_req, mem_addr
    );
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with whole-line fill from a word-wide memory.
// Optional hit/miss counters are enabled by defining ICACHE_STATS_EN.
module inst_cache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    inst_cache_if.slave  bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
`endif
);
    localparam int OW = $clog2(WORDS);
    localparam int IW = $clog2(LINES);
    localparam int AW = OW + IW;
    localparam int TW = 16 - AW;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_FILL = 1'b1} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LINES-1:0]    r_valid;
    logic [TW-1:0]       r_tag  [LINES];
    logic [15:0]         r_data [LINES*WORDS];
    logic [TW-1:0]       r_fill_tag;
    logic [IW-1:0]       r_fill_idx;
    logic [OW-1:0]       r_cnt;

    logic [OW-1:0]       w_off;
    logic [IW-1:0]       w_idx;
    logic [TW-1:0]       w_tag;
    logic                w_hit;
    logic                w_last;

    assign w_off  = bus.addr[OW-1:0];
    assign w_idx  = bus.addr[AW-1:OW];
    assign w_tag  = bus.addr[15:AW];
    assign w_hit  = (r_state == ST_IDLE) && r_valid[w_idx] &&
                    (r_tag[w_idx] == w_tag) && !bus.flush;
    assign w_last = (r_cnt == OW'(WORDS - 1));

    assign bus.hit      = w_hit;
    assign bus.inst     = r_data[{w_idx, w_off}];
    assign bus.mem_req  = (r_state == ST_FILL);
    assign bus.mem_addr = {r_fill_tag, r_fill_idx, r_cnt};

    // Next-state selection: miss starts a fill, last ready word or flush ends it.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!bus.flush && !w_hit) begin
                    w_next = ST_FILL;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (bus.flush || (bus.mem_ready && w_last)) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_FILL;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Valid bits and fill bookkeeping; the target line is invalidated while it is rewritten.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_valid    <= '0;
            r_cnt      <= '0;
            r_fill_tag <= '0;
            r_fill_idx <= '0;
        end else if (r_state == ST_IDLE) begin
            if (!w_hit) begin
                r_fill_tag     <= w_tag;
                r_fill_idx     <= w_idx;
                r_cnt          <= '0;
                r_valid[w_idx] <= 1'b0;
            end
        end else if (bus.mem_ready) begin
            r_cnt <= r_cnt + OW'(1);
            if (w_last) begin
                r_valid[r_fill_idx] <= 1'b1;
            end
        end
    end

    // Data and tag arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && (r_state == ST_FILL) && bus.mem_ready) begin
            r_data[{r_fill_idx, r_cnt}] <= bus.mem_data;
            if (w_last) begin
                r_tag[r_fill_idx] <= r_fill_tag;
            end
        end
    end

`ifdef ICACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating hit/miss counters; a miss is counted on the IDLE->FILL transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_count  <= 16'h0000;
            r_miss_count <= 16'h0000;
        end else begin
            if (w_hit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'h0001;
            end
            if ((r_state == ST_IDLE) && (w_next == ST_FILL) && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'h0001;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif
endmodule

// File: tb/tb_inst_cache.sv
// Scoreboard bench for inst_cache: expected fill addresses and instruction words are queued
// at stimulus time and popped when the cache requests memory or reports a hit.
module tb_inst_cache;
    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic clk;
    logic rst;
    inst_cache_if bus ();

`ifdef ICACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    inst_cache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [15:0] q_addr[$];
    logic [15:0] q_inst[$];
    bit          rdy_pat[16];
    int          rdy_len = 0;
    int          last_fill_cycles = 0;

    function automatic logic [15:0] img(input logic [15:0] a);
        return (a * 16'd7) ^ 16'h5A3C;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing memory image answers whatever address the cache requests.
    assign bus.mem_data = img(bus.mem_addr);

    task automatic access(input logic [15:0] a, input bit miss);
        int cyc;
        int k;
        logic [15:0] exp;
        bus.addr      = a;
        bus.flush     = 1'b0;
        bus.mem_ready = 1'b1;
        q_inst.push_back(img(a));
        if (miss) begin
            @(negedge clk);
            checks++;
            if (bus.hit !== 1'b0) begin errors++; $display("FAIL miss_detect_hit addr=%h got=%b want=0", a, bus.hit); end
            checks++;
            if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL miss_detect_req addr=%h got=%b want=0", a, bus.mem_req); end
            for (int w = 0; w < WORDS; w++) begin
                q_addr.push_back((a & ~16'(WORDS - 1)) | 16'(w));
            end
            @(posedge clk); #1;
            cyc = 0;
            k   = 0;
            while (q_addr.size() != 0 && cyc < 20) begin
                bus.mem_ready = (rdy_len == 0) ? 1'b1 : rdy_pat[k % rdy_len];
                k++;
                @(negedge clk);
                checks++;
                if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL fill_req cyc=%0d got=%b want=1", cyc, bus.mem_req); end
                checks++;
                if (bus.mem_addr !== q_addr[0]) begin errors++; $display("FAIL fill_addr cyc=%0d got=%h want=%h", cyc, bus.mem_addr, q_addr[0]); end
                if (bus.mem_ready) void'(q_addr.pop_front());
                @(posedge clk); #1;
                cyc++;
            end
            checks++;
            if (q_addr.size() != 0) begin
                errors++;
                $display("FAIL fill_timeout addr=%h got=%0d_left want=0_left", a, q_addr.size());
                q_addr.delete();
            end
            last_fill_cycles = cyc;
            bus.mem_ready = 1'b1;
        end
        @(negedge clk);
        exp = q_inst.pop_front();
        checks++;
        if (bus.hit !== 1'b1) begin errors++; $display("FAIL hit addr=%h got=%b want=1", a, bus.hit); end
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL idle_req addr=%h got=%b want=0", a, bus.mem_req); end
        checks++;
        if (bus.inst !== exp) begin errors++; $display("FAIL inst addr=%h got=%h want=%h", a, bus.inst, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.addr = 16'h0000; bus.flush = 1'b0; bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.hit !== 1'b0) begin errors++; $display("FAIL reset_hit got=%b want=0", bus.hit); end
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b want=0", bus.mem_req); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_cold_fill_and_hits();
        access(16'h0000, 1'b1);
        checks++;
        if (last_fill_cycles != WORDS) begin errors++; $display("FAIL fill_len got=%0d want=%0d", last_fill_cycles, WORDS); end
        access(16'h0001, 1'b0);
        access(16'h0002, 1'b0);
        access(16'h0003, 1'b0);
`ifdef ICACHE_STATS_EN
        @(negedge clk);
        checks++;
        if (hit_count !== 16'd4) begin errors++; $display("FAIL hit_count got=%0d want=4", hit_count); end
        checks++;
        if (miss_count !== 16'd1) begin errors++; $display("FAIL miss_count got=%0d want=1", miss_count); end
        @(posedge clk); #1;
`endif
    endtask

    task automatic test_conflict();
        access(16'h0040, 1'b1);
        access(16'h0042, 1'b0);
        access(16'h0000, 1'b1);
        access(16'h0043, 1'b1);
    endtask

    task automatic test_ready_toggle();
        rdy_pat[0] = 1'b1; rdy_pat[1] = 1'b0; rdy_pat[2] = 1'b0; rdy_pat[3] = 1'b1;
        rdy_pat[4] = 1'b1; rdy_pat[5] = 1'b0; rdy_pat[6] = 1'b1;
        rdy_len = 7;
        access(16'h0021, 1'b1);
        rdy_len = 0;
        checks++;
        if (last_fill_cycles != 7) begin errors++; $display("FAIL toggle_len got=%0d want=7", last_fill_cycles); end
        access(16'h0022, 1'b0);
    endtask

    task automatic test_reset_during_fill();
        bus.addr = 16'h0030; bus.flush = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_fill_req got=%b want=0", bus.mem_req); end
`ifdef ICACHE_STATS_EN
        checks++;
        if (hit_count !== 16'd0) begin errors++; $display("FAIL rst_hit_count got=%0d want=0", hit_count); end
        checks++;
        if (miss_count !== 16'd0) begin errors++; $display("FAIL rst_miss_count got=%0d want=0", miss_count); end
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        access(16'h0020, 1'b1);
    endtask

    task automatic test_flush();
        bus.addr = 16'h0010; bus.flush = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.hit !== 1'b0) begin errors++; $display("FAIL flush_pre_hit got=%b want=0", bus.hit); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.mem_addr !== 16'h0010) begin errors++; $display("FAIL flush_w0 got=%h want=0010", bus.mem_addr); end
        @(posedge clk); #1;
        bus.flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.mem_addr !== 16'h0011) begin errors++; $display("FAIL flush_w1 got=%h want=0011", bus.mem_addr); end
        @(posedge clk); #1;
        access(16'h0010, 1'b1);
        access(16'h0020, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            access(16'h0010 + 16'(i), 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_cold_fill_and_hits();
        test_conflict();
        test_ready_toggle();
        test_reset_during_fill();
        test_flush();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 Parameter: LINES, 16, number of direct-mapped lines (power of two, 4..64).
REQ-002 Parameter: WORDS, 4, 16-bit words per line (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 addr  input  16  instruction word address from pc_reg currentInst.
REQ-006 flush  input  1  invalidate all lines.
REQ-007 inst  output  16  instruction word at addr; valid only while hit=1.
REQ-008 hit  output  1  addr present and cache idle; drives pc_reg hit (PC advances only when 1).
REQ-009 mem_req  output  1  line-fill request to backing instruction memory.
REQ-010 mem_addr  output  16  word address of fill word currently requested.
REQ-011 mem_ready  input  1  memory has mem_data valid for mem_addr this cycle.
REQ-012 mem_data  input  16  fill data word.

Function
REQ-013 Address split: offset = low log2(WORDS) bits, index = next log2(LINES) bits, tag = remaining upper bits.
REQ-014 Storage: per line one valid bit, one tag, WORDS data words; data and tags not reset.
REQ-015 FSM states: IDLE, FILL.
REQ-016 hit = (state==IDLE) && valid[index] && tag[index]==addr tag && !flush; combinational, same-cycle as addr.
REQ-017 inst = data[index][offset], combinational; value is don't-care when hit=0.
REQ-018 IDLE and miss (hit=0, flush=0): latch addr tag and index, clear fill counter, go FILL next edge.
REQ-019 FILL: mem_req=1; mem_addr = {latched tag, latched index, fill counter}; both derived from registered state only.
REQ-020 FILL and mem_ready=1: write mem_data to data[latched index][counter], increment counter.
REQ-021 FILL, mem_ready=1, counter==WORDS-1: write tag, set valid, go IDLE; mem_req=0 the following cycle.
REQ-022 Miss penalty with mem_ready held 1: 1 detect cycle + WORDS fill cycles; hit=1 on cycle WORDS+1 after miss.
REQ-023 FILL and mem_ready=0: hold counter, mem_addr, mem_req; no write.
REQ-024 addr changes during FILL are ignored; fill completes for latched line; lookup resumes in IDLE with current addr.
REQ-025 mem_ready while state==IDLE is ignored.
REQ-026 flush in IDLE: clear all valid bits next edge; no fill started that cycle.
REQ-027 flush in FILL: abort fill, clear all valid bits, go IDLE; partially written line stays invalid.
REQ-028 Fill overwrites the indexed line unconditionally (no replacement choice).

Reset
REQ-029 rst=1: state=IDLE, all valid bits=0, fill counter=0, next cycle mem_req=0, hit=0.
REQ-030 rst during FILL aborts the fill identically; rst has priority over flush and mem_ready.

Configuration
REQ-031 Macro ICACHE_STATS_EN defined: add outputs hit_count[15:0] and miss_count[15:0].
REQ-032 With ICACHE_STATS_EN: hit_count +1 each cycle hit=1; miss_count +1 on each IDLE->FILL transition; both saturate at 0xFFFF; both reset to 0 by rst.
REQ-033 Without ICACHE_STATS_EN: counter ports and logic absent; all other behaviour identical.

Verification
REQ-034 Reset, addr=0x0000 -> hit=0; next cycle mem_req=1, mem_addr=0x0000; mem_ready=1 constant -> mem_addr 0x0000..0x0003 over 4 cycles, then hit=1, inst=word loaded for 0x0000.
REQ-035 After REQ-034 fill, addr=0x0001,0x0002,0x0003 -> hit=1 each cycle, inst matches memory image, mem_req=0.
REQ-036 Conflict: addr=0x0040 (same index 0, tag 1) -> miss, fill 0x0040..0x0043; then addr=0x0000 -> miss again.
REQ-037 Fill with mem_ready toggling 1,0,0,1,1,0,1 -> mem_addr holds while 0; line completes after exactly 4 ready pulses.
REQ-038 flush asserted at second fill word of 0x0010 -> mem_req=0 next cycle, addr=0x0010 misses and refills from 0x0010.
REQ-039 ICACHE_STATS_EN: REQ-034 then 3 hit cycles -> miss_count=1, hit_count=4; rst -> both 0.
